ahb_split_ctrl: RTL and testbench

Split-response controller for a slow AHB slave. While the slave's backing resource is busy, the block answers new transfers with the two-cycle AHB SPLIT response. It records the requesting master in a pending mask. When the resource frees up, it releases pending masters one at a time, round-robin, by pulsing the matching HSPLIT bit, which the bus arbiter consumes to re-enable that master's requests.

---
 rtl/ahb_split_ctrl.sv | 115 +++++++++++
 tb/tb_ahb_split_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_split_ctrl.sv
// AHB split-response controller: answers SPLIT/ERROR while the resource is
// busy and releases pending masters round-robin through HSPLIT.
module ahb_split_ctrl #(
   parameter int NUM_MASTERS = 16
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic                   HSEL,
   input  logic [1:0]             HTRANS,
   input  logic                   HREADY,
   input  logic [3:0]             HMASTER,
   input  logic                   res_busy,
   input  logic                   res_release,
   output logic                   HREADYOUT,
   output logic [1:0]             HRESP,
   output logic [NUM_MASTERS-1:0] HSPLIT,
   output logic                   res_start,
   output logic [3:0]             res_master,
   output logic [4:0]             pending_cnt
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RESP1 = 2'd1;
   localparam logic [1:0] RESP2 = 2'd2;

   localparam logic [1:0] OKAY  = 2'b00;
   localparam logic [1:0] ERROR = 2'b01;
   localparam logic [1:0] SPLIT = 2'b11;

   localparam logic [4:0] NM = 5'(NUM_MASTERS);
   localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

   logic [1:0]             state, state_n;
   logic [1:0]             resp_q, resp_n;
   logic [3:0]             id_q;
   logic [3:0]             rr_ptr, rr_n;
   logic [3:0]             rel_idx;
   logic                   rel_hit;
   logic [NUM_MASTERS-1:0] pending;
   logic [NUM_MASTERS-1:0] set_vec, clr_vec;
   logic                   accept, take, id_ok;
   logic [4:0]             j, nx;
   logic [4:0]             cnt;

   assign accept = HSEL & HREADY & HTRANS[1];
   assign take   = accept & (state != RESP1);
   assign id_ok  = ({1'b0, HMASTER} < NM);

   always_comb begin
      state_n = IDLE;
      resp_n  = resp_q;
      if (state == RESP1) begin
         state_n = RESP2;
      end else if (take & res_busy) begin
         state_n = RESP1;
         resp_n  = id_ok ? SPLIT : ERROR;
      end
   end

   assign set_vec = (state == RESP2 && resp_q == SPLIT) ? (ONE << id_q) : '0;

   // Round-robin scan of the pre-edge mask starting at rr_ptr.
   always_comb begin
      rel_hit = 1'b0;
      rel_idx = '0;
      j       = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         j = {1'b0, rr_ptr} + 5'(i);
         if (j >= NM) j = j - NM;
         if (!rel_hit && res_release && ((pending >> j) & ONE) != '0) begin
            rel_hit = 1'b1;
            rel_idx = j[3:0];
         end
      end
      nx   = {1'b0, rel_idx} + 5'd1;
      rr_n = (nx == NM) ? 4'd0 : nx[3:0];
   end

   assign clr_vec = rel_hit ? (ONE << rel_idx) : '0;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_MASTERS; i++) cnt = cnt + 5'(pending[i]);
   end

   assign pending_cnt = cnt;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= IDLE;
         resp_q     <= OKAY;
         id_q       <= '0;
         rr_ptr     <= '0;
         pending    <= '0;
         HREADYOUT  <= 1'b1;
         HRESP      <= OKAY;
         HSPLIT     <= '0;
         res_start  <= 1'b0;
         res_master <= '0;
      end else begin
         state     <= state_n;
         resp_q    <= resp_n;
         HREADYOUT <= (state_n != RESP1);
         HRESP     <= (state_n == IDLE) ? OKAY : resp_n;
         res_start <= take & ~res_busy;
         if (take & ~res_busy) res_master <= HMASTER;
         if (take & res_busy) id_q <= HMASTER;
         // A master being recorded this edge is not eligible; its bit survives.
         pending <= (pending & ~clr_vec) | set_vec;
         HSPLIT  <= clr_vec;
         if (rel_hit) rr_ptr <= rr_n;
      end
   end

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// Directed bench for ahb_split_ctrl: one 16-master and one 8-master
// instance share the stimulus.
module tb_ahb_split_ctrl;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        HSEL, HREADY, res_busy, res_release;
   logic [1:0]  HTRANS;
   logic [3:0]  HMASTER;

   logic        a_HREADYOUT, a_res_start;
   logic [1:0]  a_HRESP;
   logic [15:0] a_HSPLIT;
   logic [3:0]  a_res_master;
   logic [4:0]  a_pending_cnt;

   logic        b_HREADYOUT, b_res_start;
   logic [1:0]  b_HRESP;
   logic [7:0]  b_HSPLIT;
   logic [3:0]  b_res_master;
   logic [4:0]  b_pending_cnt;

   int checks = 0;
   int passes = 0;

   ahb_split_ctrl #(.NUM_MASTERS(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
      .HREADY(HREADY), .HMASTER(HMASTER), .res_busy(res_busy),
      .res_release(res_release), .HREADYOUT(a_HREADYOUT), .HRESP(a_HRESP),
      .HSPLIT(a_HSPLIT), .res_start(a_res_start), .res_master(a_res_master),
      .pending_cnt(a_pending_cnt)
   );

   ahb_split_ctrl #(.NUM_MASTERS(8)) dut8 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
      .HREADY(HREADY), .HMASTER(HMASTER), .res_busy(res_busy),
      .res_release(res_release), .HREADYOUT(b_HREADYOUT), .HRESP(b_HRESP),
      .HSPLIT(b_HSPLIT), .res_start(b_res_start), .res_master(b_res_master),
      .pending_cnt(b_pending_cnt)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL timeout: sim time %0t exceeded bound", $time);
      $fatal(1);
   end

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_in();
      HSEL = 0; HTRANS = 2'b00; HREADY = 1; HMASTER = 0;
      res_busy = 0; res_release = 0;
   endtask

   task automatic do_reset();
      idle_in();
      HRESETn = 0;
      cyc();
      HRESETn = 1;
      cyc();
   endtask

   task automatic capture(input logic [3:0] m, input logic rel_last);
      HSEL = 1; HTRANS = 2'b10; HMASTER = m; HREADY = 1; res_busy = 1;
      cyc();
      HSEL = 0; HTRANS = 2'b00; HREADY = 0;
      cyc();
      HREADY = 1; res_release = rel_last;
      cyc();
      res_release = 0; res_busy = 0;
   endtask

   task automatic test_reset();
      idle_in();
      #1 HRESETn = 0;
      #2;
      checks++; if (a_HREADYOUT !== 1'b1) $display("FAIL rst_hreadyout got %b want 1", a_HREADYOUT); else passes++;
      checks++; if (a_HRESP !== 2'b00) $display("FAIL rst_hresp got %b want 00", a_HRESP); else passes++;
      checks++; if (a_HSPLIT !== 16'h0) $display("FAIL rst_hsplit got %h want 0000", a_HSPLIT); else passes++;
      checks++; if (a_res_start !== 1'b0) $display("FAIL rst_res_start got %b want 0", a_res_start); else passes++;
      checks++; if (a_res_master !== 4'd0) $display("FAIL rst_res_master got %0d want 0", a_res_master); else passes++;
      checks++; if (a_pending_cnt !== 5'd0) $display("FAIL rst_pending_cnt got %0d want 0", a_pending_cnt); else passes++;
      cyc();
      HRESETn = 1;
      cyc();
   endtask

   task automatic test_accept();
      HSEL = 1; HTRANS = 2'b10; HMASTER = 3;
      cyc();
      idle_in();
      checks++; if (a_res_start !== 1'b1) $display("FAIL acc_res_start got %b want 1", a_res_start); else passes++;
      checks++; if (a_res_master !== 4'd3) $display("FAIL acc_res_master got %0d want 3", a_res_master); else passes++;
      checks++; if (a_HRESP !== 2'b00) $display("FAIL acc_hresp got %b want 00", a_HRESP); else passes++;
      checks++; if (a_HREADYOUT !== 1'b1) $display("FAIL acc_hreadyout got %b want 1", a_HREADYOUT); else passes++;
      checks++; if (a_pending_cnt !== 5'd0) $display("FAIL acc_pending_cnt got %0d want 0", a_pending_cnt); else passes++;
      cyc();
      checks++; if (a_res_start !== 1'b0) $display("FAIL acc_res_start_pulse got %b want 0", a_res_start); else passes++;
   endtask

   task automatic test_busy_capture();
      HSEL = 1; HTRANS = 2'b10; HMASTER = 5; res_busy = 1;
      cyc();
      checks++; if (a_HREADYOUT !== 1'b0) $display("FAIL cap_r1_hreadyout got %b want 0", a_HREADYOUT); else passes++;
      checks++; if (a_HRESP !== 2'b11) $display("FAIL cap_r1_hresp got %b want 11", a_HRESP); else passes++;
      HSEL = 0; HTRANS = 2'b00; HREADY = 0;
      cyc();
      checks++; if (a_HREADYOUT !== 1'b1) $display("FAIL cap_r2_hreadyout got %b want 1", a_HREADYOUT); else passes++;
      checks++; if (a_HRESP !== 2'b11) $display("FAIL cap_r2_hresp got %b want 11", a_HRESP); else passes++;
      checks++; if (a_pending_cnt !== 5'd0) $display("FAIL cap_r2_cnt got %0d want 0", a_pending_cnt); else passes++;
      HREADY = 1; res_busy = 0;
      cyc();
      checks++; if (a_HRESP !== 2'b00) $display("FAIL cap_done_hresp got %b want 00", a_HRESP); else passes++;
      checks++; if (dut.pending !== 16'h0020) $display("FAIL cap_pending got %h want 0020", dut.pending); else passes++;
      checks++; if (a_pending_cnt !== 5'd1) $display("FAIL cap_cnt got %0d want 1", a_pending_cnt); else passes++;
   endtask

   task automatic test_round_robin();
      logic [15:0] exp_split [3];
      logic [4:0]  exp_cnt [3];
      exp_split = '{16'h1000, 16'h0004, 16'h0080};
      exp_cnt   = '{5'd2, 5'd1, 5'd0};
      do_reset();
      capture(7, 1'b0);
      res_release = 1;
      cyc();
      res_release = 0;
      checks++; if (a_HSPLIT !== 16'h0080) $display("FAIL rr_prep_hsplit got %h want 0080", a_HSPLIT); else passes++;
      cyc();
      capture(2, 1'b0);
      capture(7, 1'b0);
      capture(12, 1'b0);
      checks++; if (a_pending_cnt !== 5'd3) $display("FAIL rr_cnt3 got %0d want 3", a_pending_cnt); else passes++;
      for (int k = 0; k < 3; k++) begin
         res_release = 1;
         cyc();
         res_release = 0;
         checks++; if (a_HSPLIT !== exp_split[k]) $display("FAIL rr_hsplit%0d got %h want %h", k, a_HSPLIT, exp_split[k]); else passes++;
         checks++; if (a_pending_cnt !== exp_cnt[k]) $display("FAIL rr_cnt%0d got %0d want %0d", k, a_pending_cnt, exp_cnt[k]); else passes++;
         cyc();
         checks++; if (a_HSPLIT !== 16'h0) $display("FAIL rr_pulse%0d got %h want 0000", k, a_HSPLIT); else passes++;
      end
      checks++; if (dut.rr_ptr !== 4'd8) $display("FAIL rr_ptr_end got %0d want 8", dut.rr_ptr); else passes++;
   endtask

   task automatic test_release_empty();
      res_release = 1;
      cyc();
      res_release = 0;
      checks++; if (a_HSPLIT !== 16'h0) $display("FAIL empty_hsplit got %h want 0000", a_HSPLIT); else passes++;
      checks++; if (dut.rr_ptr !== 4'd8) $display("FAIL empty_rr_ptr got %0d want 8", dut.rr_ptr); else passes++;
      cyc();
   endtask

   task automatic test_collision();
      do_reset();
      capture(9, 1'b0);
      capture(4, 1'b1);
      checks++; if (a_HSPLIT !== 16'h0200) $display("FAIL col_hsplit got %h want 0200", a_HSPLIT); else passes++;
      checks++; if (dut.pending !== 16'h0010) $display("FAIL col_pending got %h want 0010", dut.pending); else passes++;
      cyc();
   endtask

   task automatic test_back_to_back();
      do_reset();
      HSEL = 1; HTRANS = 2'b10; HMASTER = 1; res_busy = 1;
      cyc();
      HSEL = 0; HREADY = 0;
      cyc();
      HSEL = 1; HREADY = 1; HMASTER = 3;
      cyc();
      checks++; if (a_HREADYOUT !== 1'b0) $display("FAIL b2b_hreadyout got %b want 0", a_HREADYOUT); else passes++;
      checks++; if (a_HRESP !== 2'b11) $display("FAIL b2b_hresp got %b want 11", a_HRESP); else passes++;
      checks++; if (dut.pending !== 16'h0002) $display("FAIL b2b_pending1 got %h want 0002", dut.pending); else passes++;
      HSEL = 0; HREADY = 0;
      cyc();
      HSEL = 1; HREADY = 1; HMASTER = 6; res_busy = 0;
      cyc();
      idle_in();
      checks++; if (a_res_start !== 1'b1) $display("FAIL b2b_res_start got %b want 1", a_res_start); else passes++;
      checks++; if (a_res_master !== 4'd6) $display("FAIL b2b_res_master got %0d want 6", a_res_master); else passes++;
      checks++; if (a_HRESP !== 2'b00) $display("FAIL b2b_hresp_ok got %b want 00", a_HRESP); else passes++;
      checks++; if (dut.pending !== 16'h000A) $display("FAIL b2b_pending2 got %h want 000a", dut.pending); else passes++;
      cyc();
   endtask

   task automatic test_invalid_id();
      do_reset();
      HSEL = 1; HTRANS = 2'b10; HMASTER = 10; res_busy = 1;
      cyc();
      checks++; if (b_HREADYOUT !== 1'b0) $display("FAIL inv_r1_hreadyout got %b want 0", b_HREADYOUT); else passes++;
      checks++; if (b_HRESP !== 2'b01) $display("FAIL inv_r1_hresp got %b want 01", b_HRESP); else passes++;
      HSEL = 0; HTRANS = 2'b00; HREADY = 0;
      cyc();
      checks++; if (b_HREADYOUT !== 1'b1) $display("FAIL inv_r2_hreadyout got %b want 1", b_HREADYOUT); else passes++;
      checks++; if (b_HRESP !== 2'b01) $display("FAIL inv_r2_hresp got %b want 01", b_HRESP); else passes++;
      HREADY = 1; res_busy = 0;
      cyc();
      checks++; if (b_HRESP !== 2'b00) $display("FAIL inv_done_hresp got %b want 00", b_HRESP); else passes++;
      checks++; if (b_pending_cnt !== 5'd0) $display("FAIL inv_cnt got %0d want 0", b_pending_cnt); else passes++;
      checks++; if (a_pending_cnt !== 5'd1) $display("FAIL inv_wide_cnt got %0d want 1", a_pending_cnt); else passes++;
      res_release = 1;
      cyc();
      res_release = 0;
      checks++; if (b_HSPLIT !== 8'h00) $display("FAIL inv_hsplit got %h want 00", b_HSPLIT); else passes++;
      checks++; if (a_HSPLIT !== 16'h0400) $display("FAIL inv_wide_hsplit got %h want 0400", a_HSPLIT); else passes++;
      cyc();
   endtask

   task automatic test_reset_mid();
      do_reset();
      capture(0, 1'b0);
      capture(1, 1'b0);
      checks++; if (dut.pending !== 16'h0003) $display("FAIL rm_pending got %h want 0003", dut.pending); else passes++;
      HSEL = 1; HTRANS = 2'b10; HMASTER = 6; res_busy = 1;
      cyc();
      checks++; if (a_HREADYOUT !== 1'b0) $display("FAIL rm_r1_hreadyout got %b want 0", a_HREADYOUT); else passes++;
      HSEL = 0; HTRANS = 2'b00; HREADY = 0;
      #2 HRESETn = 0;
      #1;
      checks++; if (a_HREADYOUT !== 1'b1) $display("FAIL rm_hreadyout got %b want 1", a_HREADYOUT); else passes++;
      checks++; if (a_HRESP !== 2'b00) $display("FAIL rm_hresp got %b want 00", a_HRESP); else passes++;
      checks++; if (a_pending_cnt !== 5'd0) $display("FAIL rm_cnt got %0d want 0", a_pending_cnt); else passes++;
      cyc();
      HRESETn = 1;
      idle_in();
      res_release = 1;
      cyc();
      res_release = 0;
      checks++; if (a_HSPLIT !== 16'h0) $display("FAIL rm_hsplit got %h want 0000", a_HSPLIT); else passes++;
      cyc();
   endtask

   initial begin
      test_reset();
      test_accept();
      test_busy_capture();
      test_round_robin();
      test_release_empty();
      test_collision();
      test_back_to_back();
      test_invalid_id();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
